// File: rtl/conv_scheduler.sv
// conv_scheduler: sequences a raster pixel stream through a KxK window datapath,
// tracks the fixed 2-cycle datapath latency, and buffers results in a small
// first-word-fall-through FIFO with credit-based backpressure toward the source.
module conv_scheduler #(
   parameter int unsigned KERNEL_SIZE = 3,
   parameter int unsigned WORD_SIZE   = 16,
   parameter int unsigned IMG_WIDTH   = 16,
   parameter int unsigned IMG_HEIGHT  = 16,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   output logic                        busy,
   output logic                        frame_done,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        win_shift,
   output logic                        win_valid,
   input  logic signed [WORD_SIZE-1:0] conv_ans,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [WORD_SIZE-1:0] out_data,
   output logic                        out_last
);

   localparam int unsigned ColW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int unsigned RowW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned Total = (IMG_HEIGHT - KERNEL_SIZE + 1) * (IMG_WIDTH - KERNEL_SIZE + 1);
   localparam int unsigned ResW  = $clog2(Total + 1);

   localparam logic [ColW-1:0] ColLast     = ColW'(IMG_WIDTH - 1);
   localparam logic [RowW-1:0] RowLast     = RowW'(IMG_HEIGHT - 1);
   localparam logic [ColW-1:0] ColFirstWin = ColW'(KERNEL_SIZE - 1);
   localparam logic [RowW-1:0] RowFirstWin = RowW'(KERNEL_SIZE - 1);
   localparam logic [ResW-1:0] ResLast     = ResW'(Total - 1);
   localparam logic [CntW:0]   DepthLim    = (CntW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e               state_q, state_d;
   logic [ColW-1:0]      col_q, col_d;
   logic [RowW-1:0]      row_q, row_d;
   logic [1:0]           vld_q, vld_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [ResW-1:0]      res_cnt_q, res_cnt_d;
   // Each entry carries the frame-last flag above the data word.
   logic [WORD_SIZE:0]   mem_q [FIFO_DEPTH];
   logic [WORD_SIZE:0]   mem_d [FIFO_DEPTH];

   logic [1:0]           inflight;
   logic [CntW:0]        credit_use;
   logic                 credit_ok;
   logic                 frame_start;
   logic                 push;
   logic                 pop;
   logic                 push_last;
   logic [WORD_SIZE:0]   head;
   logic                 head_last;
   logic                 drain_done;

   // Credit: queued results plus results still inside the datapath must fit the FIFO.
   always_comb begin
      inflight   = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};
      credit_use = (CntW + 1)'(count_q) + (CntW + 1)'(inflight);
      credit_ok  = credit_use < DepthLim;
   end

   // Frame sequencing FSM, raster counters and handshake outputs.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      busy        = 1'b0;
      frame_done  = 1'b0;
      in_ready    = 1'b0;
      win_shift   = 1'b0;
      win_valid   = 1'b0;
      frame_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StRun;
               col_d       = '0;
               row_d       = '0;
               frame_start = 1'b1;
            end
         end
         StRun: begin
            busy      = 1'b1;
            in_ready  = credit_ok;
            win_shift = in_valid && credit_ok;
            // Window is complete once the shifted pixel is at least K-1 into both axes.
            win_valid = win_shift && (row_q >= RowFirstWin) && (col_q >= ColFirstWin);
            if (win_shift) begin
               if (col_q == ColLast) begin
                  col_d = '0;
                  if (row_q == RowLast) begin
                     row_d   = '0;
                     state_d = StDrain;
                  end else begin
                     row_d = row_q + RowW'(1);
                  end
               end else begin
                  col_d = col_q + ColW'(1);
               end
            end
         end
         StDrain: begin
            busy = 1'b1;
            if (drain_done) begin
               state_d = StDone;
            end
         end
         StDone: begin
            frame_done = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Latency tracking, output FIFO bookkeeping and result numbering.
   always_comb begin
      vld_d      = {vld_q[0], win_valid};
      push       = vld_q[1];
      out_valid  = (count_q != '0);
      pop        = out_valid && out_ready;
      push_last  = (res_cnt_q == ResLast);
      head       = mem_q[rd_ptr_q];
      head_last  = head[WORD_SIZE];
      out_data   = out_valid ? head[WORD_SIZE-1:0] : '0;
      out_last   = out_valid && head_last;
      // The last result is the final entry, so popping it with nothing in flight ends the frame.
      drain_done = pop && head_last && (vld_q == 2'b00);

      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      res_cnt_d = res_cnt_q;

      if (push) begin
         mem_d[wr_ptr_q] = {push_last, conv_ans};
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      if (frame_start) begin
         res_cnt_d = '0;
      end else if (push) begin
         res_cnt_d = res_cnt_q + ResW'(1);
      end
   end

   // State registers; reset discards any frame in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         col_q     <= '0;
         row_q     <= '0;
         vld_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         res_cnt_q <= '0;
         mem_q     <= '{default: '0};
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         vld_q     <= vld_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         res_cnt_q <= res_cnt_d;
         mem_q     <= mem_d;
      end
   end

endmodule

// File: tb/tb_conv_scheduler.sv
// Bench for conv_scheduler: a default-size instance and a 5x5-kernel 8x8 instance
// share stimulus; a frame-level reference model predicts every handshake and result.
module tb_conv_scheduler;

   localparam int WS    = 16;
   localparam int DEPTH = 4;
   localparam int MIdle   = 0;
   localparam int MActive = 1;
   localparam int MDone   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, start, in_valid, out_ready, use_b;
   logic signed [WS-1:0] conv_ans;
   logic start_a, start_b;

   logic a_busy, a_fd, a_ir, a_ws, a_wv, a_ov, a_ol;
   logic b_busy, b_fd, b_ir, b_ws, b_wv, b_ov, b_ol;
   logic signed [WS-1:0] a_od, b_od;

   logic m_busy, m_fd, m_ir, m_ws, m_wv, m_ov, m_ol;
   logic signed [WS-1:0] m_od;

   assign start_a = start & ~use_b;
   assign start_b = start & use_b;
   assign m_busy  = use_b ? b_busy : a_busy;
   assign m_fd    = use_b ? b_fd   : a_fd;
   assign m_ir    = use_b ? b_ir   : a_ir;
   assign m_ws    = use_b ? b_ws   : a_ws;
   assign m_wv    = use_b ? b_wv   : a_wv;
   assign m_ov    = use_b ? b_ov   : a_ov;
   assign m_ol    = use_b ? b_ol   : a_ol;
   assign m_od    = use_b ? b_od   : a_od;

   conv_scheduler u_dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start_a),
      .busy       (a_busy),
      .frame_done (a_fd),
      .in_valid   (in_valid),
      .in_ready   (a_ir),
      .win_shift  (a_ws),
      .win_valid  (a_wv),
      .conv_ans   (conv_ans),
      .out_valid  (a_ov),
      .out_ready  (out_ready),
      .out_data   (a_od),
      .out_last   (a_ol)
   );

   conv_scheduler #(
      .KERNEL_SIZE (5),
      .WORD_SIZE   (16),
      .IMG_WIDTH   (8),
      .IMG_HEIGHT  (8),
      .FIFO_DEPTH  (4)
   ) u_dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start_b),
      .busy       (b_busy),
      .frame_done (b_fd),
      .in_valid   (in_valid),
      .in_ready   (b_ir),
      .win_shift  (b_ws),
      .win_valid  (b_wv),
      .conv_ans   (conv_ans),
      .out_valid  (b_ov),
      .out_ready  (out_ready),
      .out_data   (b_od),
      .out_last   (b_ol)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: frame phase, pixels accepted, windows issued/popped and issue times.
   int K, W, H, nres;
   int ms, n_shift, issued, popped, now, obs_wv, obs_beats;
   int iss_cyc [256];
   logic [15:0] salt;
   logic signed [WS-1:0] p1, p2;

   task automatic chk1(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic chkw(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Datapath stand-in: each window's result encodes its bottom-right coordinate.
   function automatic logic signed [WS-1:0] fval(input int r, input int c);
      return WS'(int'(salt) + r * 97 + c);
   endfunction

   // j-th result of a frame, in raster order of window bottom-right pixel.
   function automatic logic signed [WS-1:0] win_val(input int j);
      int nc;
      nc = W - K + 1;
      return fval(K - 1 + j / nc, K - 1 + j % nc);
   endfunction

   task automatic set_geom(input logic b);
      use_b = b;
      K     = b ? 5 : 3;
      W     = b ? 8 : 16;
      H     = b ? 8 : 16;
      nres  = (H - K + 1) * (W - K + 1);
   endtask

   task automatic drive(input int mode);
      case (mode)
         0: begin in_valid = 1'b1; out_ready = 1'b1; end
         1: begin in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1)); end
         default: begin in_valid = 1'b1; out_ready = 1'b0; end
      endcase
   endtask

   // One clock: check all outputs at the falling edge, then advance model and datapath.
   task automatic cycle_chk();
      int r, c;
      logic e_ir, e_sh, e_wv, e_ov, do_pop;
      logic signed [WS-1:0] pin;
      @(negedge clk);
      r      = n_shift / W;
      c      = n_shift % W;
      e_ir   = (ms == MActive) && (n_shift < W * H) && ((issued - popped) < DEPTH);
      e_sh   = in_valid && e_ir;
      e_wv   = e_sh && (r >= K - 1) && (c >= K - 1);
      e_ov   = (ms == MActive) && (popped < issued) && (iss_cyc[popped] + 3 <= now);
      do_pop = e_ov && out_ready;
      chk1("in_ready", m_ir, e_ir);
      chk1("win_shift", m_ws, e_sh);
      chk1("win_valid", m_wv, e_wv);
      chk1("busy", m_busy, ms == MActive);
      chk1("frame_done", m_fd, ms == MDone);
      chk1("out_valid", m_ov, e_ov);
      if (do_pop) begin
         chkw("out_data", int'(m_od), int'(win_val(popped)));
         chk1("out_last", m_ol, popped == nres - 1);
      end
      pin = m_wv ? fval(r, c) : WS'($urandom);
      if (m_wv) obs_wv++;
      if (m_ov && out_ready) obs_beats++;
      if (e_wv) begin
         iss_cyc[issued] = now;
         issued++;
      end
      if (e_sh) n_shift++;
      case (ms)
         MIdle: begin
            if (start) begin
               ms        = MActive;
               n_shift   = 0;
               issued    = 0;
               popped    = 0;
               obs_wv    = 0;
               obs_beats = 0;
            end
         end
         MActive: begin
            if (do_pop) begin
               popped++;
               if (popped == nres) ms = MDone;
            end
         end
         default: ms = MIdle;
      endcase
      now++;
      @(posedge clk);
      p2 = p1;
      p1 = pin;
      #1;
      conv_ans = p2;
   endtask

   task automatic run_frame(input int mode, input int budget);
      int i;
      i = 0;
      while (ms != MDone && i < budget) begin
         drive(mode);
         cycle_chk();
         i++;
      end
      chk1("frame_within_budget", ms == MDone, 1'b1);
      if (ms == MDone) begin
         drive(mode);
         cycle_chk();
         chkw("beats", obs_beats, nres);
         drive(mode);
         cycle_chk();
      end
   endtask

   task automatic begin_frame();
      start = 1'b1;
      drive(0);
      cycle_chk();
      start = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      conv_ans  = '0;
      p1        = '0;
      p2        = '0;
      ms        = MIdle;
      now       = 0;
      n_shift   = 0;
      issued    = 0;
      popped    = 0;
      obs_wv    = 0;
      obs_beats = 0;
      salt      = 16'($urandom);
      set_geom(1'b0);

      // Outputs while held in reset.
      #12;
      chk1("rst_in_ready", a_ir, 1'b0);
      chk1("rst_win_shift", a_ws, 1'b0);
      chk1("rst_win_valid", a_wv, 1'b0);
      chk1("rst_out_valid", a_ov, 1'b0);
      chk1("rst_out_last", a_ol, 1'b0);
      chkw("rst_out_data", int'(a_od), 0);
      chk1("rst_busy", a_busy, 1'b0);
      chk1("rst_frame_done", a_fd, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      drive(0);
      cycle_chk();
      cycle_chk();

      // Full-rate frame with a permanently ready sink.
      begin_frame();
      run_frame(0, 1000);

      // Sink stalled through RUN: source must be throttled to FIFO_DEPTH results.
      salt = 16'($urandom);
      begin_frame();
      for (int i = 0; i < 60; i++) begin
         drive(2);
         cycle_chk();
      end
      chkw("stall_windows", obs_wv, DEPTH);
      chk1("stall_out_valid", m_ov, 1'b1);
      chk1("stall_in_ready", m_ir, 1'b0);
      run_frame(0, 1000);

      // Random source and sink activity.
      salt = 16'($urandom);
      begin_frame();
      run_frame(1, 5000);

      // Start held high across a frame: ignored while busy, restarts only from idle.
      salt  = 16'($urandom);
      start = 1'b1;
      drive(1);
      cycle_chk();
      run_frame(1, 5000);
      chk1("restart_busy", m_busy, 1'b1);
      start = 1'b0;
      run_frame(0, 1000);

      // Asynchronous reset mid-frame with results queued, then a clean frame.
      salt = 16'($urandom);
      begin_frame();
      for (int i = 0; i < 400 && n_shift < 98; i++) begin
         drive(0);
         cycle_chk();
      end
      for (int i = 0; i < 4; i++) begin
         drive(2);
         cycle_chk();
      end
      chk1("pre_reset_out_valid", m_ov, 1'b1);
      #6;
      reset_n = 1'b0;
      #1;
      chk1("async_out_valid", m_ov, 1'b0);
      chk1("async_busy", m_busy, 1'b0);
      chk1("async_in_ready", m_ir, 1'b0);
      chkw("async_out_data", int'(m_od), 0);
      ms = MIdle;
      p1 = '0;
      p2 = '0;
      @(posedge clk);
      #1;
      reset_n  = 1'b1;
      conv_ans = '0;
      drive(0);
      cycle_chk();
      begin_frame();
      run_frame(0, 1000);

      // Larger kernel on a small image.
      set_geom(1'b1);
      salt = 16'($urandom);
      drive(0);
      cycle_chk();
      begin_frame();
      run_frame(1, 2000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
